iob_fifo_ptr_flags: RTL and testbench



---
 rtl/iob_fifo_pkg.sv | 29 ++
 rtl/iob_sync.sv | 36 +++
 rtl/iob_fifo_ptr_flags.sv | 76 +++++++
 tb/tb_iob_fifo_ptr_flags.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo_pkg.sv
// rtl/iob_fifo_pkg.sv - shared gray-pointer helpers and side constants for the async FIFO
package iob_fifo_pkg;

  localparam int SIDE_WR = 0;
  localparam int SIDE_RD = 1;

  // Width-generic gray to binary; callers pass the live pointer width w and truncate the result.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = '0;
    b[w-1] = g[w-1];
    for (int i = w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when local equals remote with its top two gray bits inverted.
  function automatic logic gray_full_cmp(input logic [31:0] local_g,
                                         input logic [31:0] remote_g,
                                         input int w);
    logic [31:0] flip;
    logic [31:0] mask;
    flip = 32'h3 << (w - 2);
    mask = (32'h1 << w) - 32'h1;
    return (local_g & mask) == ((remote_g ^ flip) & mask);
  endfunction

endpackage

// File: rtl/iob_sync.sv
// rtl/iob_sync.sv - reset-to-zero multi-flop synchronizer for gray pointers
module iob_sync #(
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         rst,
  input  logic         clk,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_d [SYNC_STAGES];
  logic [W-1:0] stage_q [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/iob_fifo_ptr_flags.sv
// rtl/iob_fifo_ptr_flags.sv - per-domain pointer compare: full/empty, level, almost flag, gated enable
module iob_fifo_ptr_flags
  import iob_fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SIDE        = 0,
  parameter int ALMOST      = 1
) (
  input  logic              rst,
  input  logic              clk,
  input  logic [ADDR_W:0]   local_gray_i,
  input  logic [ADDR_W:0]   remote_gray_i,
  input  logic              req_i,
  output logic              en_o,
  output logic              flag_o,
  output logic              almost_o,
  output logic [ADDR_W:0]   level_o,
  output logic [ADDR_W:0]   remote_sync_o
);

  localparam int W     = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [W-1:0] ALMOST_FULL_TH  = W'(DEPTH - ALMOST);
  localparam logic [W-1:0] ALMOST_EMPTY_TH = W'(ALMOST);
  localparam logic         ALMOST_RST      = (SIDE == SIDE_RD);

  logic [W-1:0] local_bin;
  logic [W-1:0] remote_bin;
  logic [W-1:0] diff;
  logic         flag;
  logic         almost_d, almost_q;
  logic [W-1:0] level_d, level_q;

  iob_sync #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .rst (rst),
    .clk (clk),
    .d_i (remote_gray_i),
    .q_o (remote_sync_o)
  );

  // Differences wrap naturally mod 2^W, so pointer roll-over needs no special case.
  always_comb begin
    local_bin  = W'(gray2bin(32'(local_gray_i), W));
    remote_bin = W'(gray2bin(32'(remote_sync_o), W));
    if (SIDE == SIDE_WR) begin
      diff     = local_bin - remote_bin;
      flag     = gray_full_cmp(32'(local_gray_i), 32'(remote_sync_o), W);
      almost_d = (diff >= ALMOST_FULL_TH);
    end else begin
      diff     = remote_bin - local_bin;
      flag     = (local_gray_i == remote_sync_o);
      almost_d = (diff <= ALMOST_EMPTY_TH);
    end
    level_d = diff;
  end

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      almost_q <= ALMOST_RST;
    end else begin
      level_q  <= level_d;
      almost_q <= almost_d;
    end
  end

  assign flag_o   = flag;
  assign en_o     = req_i & ~flag;
  assign level_o  = level_q;
  assign almost_o = almost_q;

endmodule

// File: tb/tb_iob_fifo_ptr_flags.sv
// tb/tb_iob_fifo_ptr_flags.sv - self-checking bench for iob_fifo_ptr_flags
module tb_iob_fifo_ptr_flags;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] w_local, w_remote, w_level, w_rsync;
  logic       w_req, w_en, w_flag, w_almost;
  logic [2:0] r_local, r_remote, r_level, r_rsync;
  logic       r_req, r_en, r_flag, r_almost;
  logic [2:0] t_local, t_remote, t_level, t_rsync;
  logic       t_req, t_en, t_flag, t_almost;

  iob_fifo_ptr_flags #(.ADDR_W(2), .SYNC_STAGES(2), .SIDE(0), .ALMOST(1)) dut_w (
    .rst(rst), .clk(clk), .local_gray_i(w_local), .remote_gray_i(w_remote), .req_i(w_req),
    .en_o(w_en), .flag_o(w_flag), .almost_o(w_almost), .level_o(w_level), .remote_sync_o(w_rsync));

  iob_fifo_ptr_flags #(.ADDR_W(2), .SYNC_STAGES(2), .SIDE(1), .ALMOST(1)) dut_r (
    .rst(rst), .clk(clk), .local_gray_i(r_local), .remote_gray_i(r_remote), .req_i(r_req),
    .en_o(r_en), .flag_o(r_flag), .almost_o(r_almost), .level_o(r_level), .remote_sync_o(r_rsync));

  iob_fifo_ptr_flags #(.ADDR_W(2), .SYNC_STAGES(3), .SIDE(1), .ALMOST(1)) dut_t (
    .rst(rst), .clk(clk), .local_gray_i(t_local), .remote_gray_i(t_remote), .req_i(t_req),
    .en_o(t_en), .flag_o(t_flag), .almost_o(t_almost), .level_o(t_level), .remote_sync_o(t_rsync));

  typedef struct {
    logic [2:0] lg;
    logic [2:0] rg;
    logic       req;
    logic       flag;
    logic       en;
    logic [2:0] level;
    logic       almost;
  } vec_t;

  vec_t vecs[8];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  int wr_b, rd_b, s1, sb, exp_level;
  logic exp_flag;

  initial begin
    // gray order for binary 0..7: 000 001 011 010 110 111 101 100
    vecs[0] = '{3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[1] = '{3'b011, 3'b000, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0};
    vecs[2] = '{3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1};
    vecs[3] = '{3'b110, 3'b000, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1};
    vecs[4] = '{3'b001, 3'b111, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1};
    vecs[5] = '{3'b100, 3'b111, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0};
    vecs[6] = '{3'b000, 3'b100, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0};
    vecs[7] = '{3'b101, 3'b011, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1};

    rst = 1'b1;
    w_local = '0; w_remote = '0; w_req = 1'b1;
    r_local = '0; r_remote = '0; r_req = 1'b1;
    t_local = '0; t_remote = '0; t_req = 1'b1;
    neg(2);
    chk("rst_w_flag", w_flag, 0);
    chk("rst_w_en", w_en, 1);
    chk("rst_w_level", w_level, 0);
    chk("rst_w_almost", w_almost, 0);
    chk("rst_w_rsync", w_rsync, 0);
    chk("rst_r_flag", r_flag, 1);
    chk("rst_r_en", r_en, 0);
    chk("rst_r_almost", r_almost, 1);
    chk("rst_r_level", r_level, 0);
    chk("rst_t_almost", t_almost, 1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      w_local = vecs[i].lg; w_remote = vecs[i].rg; w_req = vecs[i].req;
      neg(3);
      chk($sformatf("vec%0d_flag", i), w_flag, vecs[i].flag);
      chk($sformatf("vec%0d_en", i), w_en, vecs[i].en);
      chk($sformatf("vec%0d_level", i), w_level, vecs[i].level);
      chk($sformatf("vec%0d_almost", i), w_almost, vecs[i].almost);
      chk($sformatf("vec%0d_rsync", i), w_rsync, vecs[i].rg);
    end

    // mid-stream reset with the local counter resetting alongside
    w_local = 3'b110; w_remote = 3'b000; w_req = 1'b1;
    neg(3);
    chk("t1_pre_level", w_level, 4);
    #2;
    rst = 1'b1; w_local = 3'b000;
    #1;
    chk("t1_rsync", w_rsync, 0);
    chk("t1_level", w_level, 0);
    chk("t1_flag", w_flag, 0);
    chk("t1_almost", w_almost, 0);
    neg(1);
    rst = 1'b0; w_remote = 3'b011;
    neg(2);
    chk("t1_sync_pre", w_rsync, 3'b011);
    rst = 1'b1;
    #1;
    chk("t1_sync_clear", w_rsync, 0);
    neg(1);
    rst = 1'b0; w_remote = 3'b000;
    neg(3);

    // full blocks the push immediately
    w_local = 3'b110; w_req = 1'b1;
    #1;
    chk("t2_flag", w_flag, 1);
    chk("t2_en", w_en, 0);
    neg(1);
    chk("t2_level", w_level, 4);
    chk("t2_almost", w_almost, 1);

    // wrap: local bin 1, remote moves to bin 5
    w_local = 3'b001; w_remote = 3'b000;
    neg(3);
    chk("t3_pre_level", w_level, 1);
    chk("t3_pre_flag", w_flag, 0);
    w_remote = 3'b111;
    neg(1);
    chk("t3_flag_e1", w_flag, 0);
    neg(1);
    chk("t3_flag_e2", w_flag, 1);
    chk("t3_level_e2", w_level, 1);
    neg(1);
    chk("t3_level_e3", w_level, 4);
    chk("t3_almost_e3", w_almost, 1);

    // read side: empty drops only after the sync latency
    r_local = 3'b011; r_remote = 3'b011; r_req = 1'b1;
    neg(3);
    chk("t4_pre_flag", r_flag, 1);
    chk("t4_pre_en", r_en, 0);
    chk("t4_pre_level", r_level, 0);
    r_remote = 3'b010;
    neg(1);
    chk("t4_flag_e1", r_flag, 1);
    neg(1);
    chk("t4_flag_e2", r_flag, 0);
    chk("t4_en_req1", r_en, 1);
    r_req = 1'b0;
    #1;
    chk("t4_en_req0", r_en, 0);
    r_req = 1'b1;
    neg(1);
    chk("t4_level", r_level, 1);
    chk("t4_almost", r_almost, 1);

    // three-stage synchronizer with a one-cycle remote pulse
    t_local = 3'b000; t_remote = 3'b000;
    neg(4);
    t_remote = 3'b001;
    neg(1);
    t_remote = 3'b000;
    chk("t5_rsync_e1", t_rsync, 0);
    chk("t5_flag_e1", t_flag, 1);
    neg(1);
    chk("t5_rsync_e2", t_rsync, 0);
    chk("t5_flag_e2", t_flag, 1);
    neg(1);
    chk("t5_rsync_e3", t_rsync, 3'b001);
    chk("t5_flag_e3", t_flag, 0);
    neg(1);
    chk("t5_rsync_e4", t_rsync, 0);
    chk("t5_flag_e4", t_flag, 1);

    // random push/pop against a pointer-history model
    rst = 1'b1;
    r_local = '0; r_remote = '0; r_req = 1'b0;
    wr_b = 0; rd_b = 0; s1 = 0; sb = 0;
    neg(1);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1 && ((wr_b - rd_b) & 7) < 4) wr_b = (wr_b + 1) & 7;
      r_req = 1'($urandom_range(0, 1));
      r_remote = to_gray(wr_b);
      r_local = to_gray(rd_b);
      #1;
      exp_flag = (rd_b == sb);
      chk("t6_flag", r_flag, exp_flag);
      chk("t6_en", r_en, r_req & ~exp_flag);
      @(posedge clk);
      exp_level = (sb - rd_b) & 7;
      if (r_req && !exp_flag) rd_b = (rd_b + 1) & 7;
      sb = s1;
      s1 = wr_b;
      @(negedge clk);
      chk("t6_level", r_level, exp_level);
      chk("t6_almost", r_almost, exp_level <= 1);
      chk("t6_level_range", r_level <= 3'd4, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
